muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencing controller for the EX-stage multi-cycle multiply/divide unit. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX instruction code, launches the arithmetic unit with latched operands, and stalls the pipeline while the operation runs. It owns the architectural HI/LO register and commits results to it, and aborts cleanly on exception flush. It sits between the EX-stage decode/operand path and the multi-cycle unit; its HI/LO output feeds MFHI/MFLO.

## Interface
- MUL_CYCLES, 3: unit latency for MULT/MULTU (≥1).
- DIV_CYCLES, 36: unit latency for DIV/DIVU (≥1).
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- flush  in  1  exception flush; kills the in-flight operation.
- ex_valid  in  1  EX holds a valid instruction.
- ex_hold  in  1  pipeline held by another stage; EX instruction will not advance this cycle.
- inst  in  8  EX instruction code, using the shared `INST_*` encodings.
- op1, op2  in  32 each  EX operands (rs, rt).
- unit_result  in  64  {HI,LO} result from the unit, sign-corrected by the unit.
- unit_start  out  1  one-cycle launch pulse.
- unit_abort  out  1  one-cycle abort pulse to the unit.
- unit_inst  out  8  latched instruction code.
- unit_op1, unit_op2  out  32 each  latched operands, stable from start to completion.
- stall_req  out  1  EX stall request.
- busy  out  1  state ≠ IDLE.
- hilo_o  out  64  architectural {HI,LO}.

## Operation
- States: IDLE, BUSY, DONE. Down-counter cnt, width $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- Reset: state=IDLE, cnt=0, hilo=0, unit_op1/op2/unit_inst=0, unit_start=unit_abort=0. stall_req=0 and busy=0 while in reset.
- A muldiv op is ex_valid & inst ∈ {MULT,MULTU,DIV,DIVU}.
- IDLE behaviour:
  - Muldiv op with no flush: stall_req=1 (combinational). Latch inst/op1/op2.
  - If DIV/DIVU with op2==0: go to DONE with no unit_start. HI/LO unchanged.
  - Otherwise: next cycle unit_start=1, state=BUSY, cnt=MUL_CYCLES or DIV_CYCLES.
  - MTHI/MTLO with ex_valid & !ex_hold & !flush: write hilo[63:32] or hilo[31:0] from op1 at the clock edge. No stall.
- BUSY behaviour:
  - stall_req=1. cnt decrements each cycle.
  - In the cycle with cnt==1: hilo<=unit_result at the edge, then state=DONE.
- DONE behaviour:
  - stall_req=0. The same instruction is still visible on inst but must not relaunch.
  - If ex_hold=1, stay in DONE. Otherwise go to IDLE.
- flush (any state, highest priority):
  - Next state=IDLE and cnt=0. No HI/LO write, including when cnt==1 in the same cycle.
  - No launch if flush coincides with detection in IDLE.
  - unit_abort=1 next cycle if the state was BUSY.
  - stall_req=0 in the flush cycle.
- MFHI/MFLO read hilo_o directly. Ordering guarantees that a prior MT*/muldiv has committed before a following instruction reaches EX.

## Timing
- MULT at EX in cycle 0:
  - Cycle 0: stall_req=1.
  - Cycle 1: unit_start, BUSY with cnt=N.
  - Cycle N: cnt==1; HI/LO updated at the end of cycle N.
  - Cycle N+1: DONE with stall_req=0; the instruction leaves EX at the end of cycle N+1 if !ex_hold.
  - Stall cycles = N+1 (N=MUL_CYCLES or DIV_CYCLES).
- The unit must present a valid unit_result in the N-th cycle counting the unit_start cycle as 1.
- Divide-by-zero: 1 stall cycle (cycle 0), then DONE in cycle 1.
- hilo_o changes only at clock edges. unit_op1/op2/unit_inst hold from the latch edge until the next launch.
- An asynchronous reset mid-operation returns to IDLE immediately with hilo=0. No abort pulse is generated.

## Test plan
- Reset then MULT op1=0xFFFFFFFE, op2=3, unit model returns 0xFFFFFFFF_FFFFFFFA after 3 cycles -> unit_start in cycle 1; stall_req high cycles 0-3; hilo_o=0xFFFFFFFF_FFFFFFFA from cycle 4; exactly one unit_start.
- DIVU op1=100, op2=7, DIV_CYCLES=36 -> stall_req high 37 cycles; hilo_o={2,14} after commit; no relaunch in DONE.
- DIV op2=0 with hilo preset 0x11111111_22222222 -> 1 stall cycle, unit_start never asserted, hilo unchanged.
- flush asserted in the cnt==1 cycle of a DIV -> hilo unchanged; unit_abort pulses next cycle; state IDLE; stall_req=0 in the flush cycle.
- ex_hold=1 for 3 cycles during DONE -> stays DONE, stall_req=0, no second unit_start; IDLE after hold drops.
- MTHI op1=0xDEADBEEF then MTLO op1=0x12345678 on consecutive cycles, then MFHI -> hilo_o=0xDEADBEEF_12345678, no stall; repeat with ex_hold=1 on the MTHI -> no write until hold drops.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Launch/operand/result bundle between the muldiv sequencing controller
// and the multi-cycle multiply/divide unit.
interface muldiv_ctrl_if;
  logic        unit_start;
  logic        unit_abort;
  logic [7:0]  unit_inst;
  logic [31:0] unit_op1;
  logic [31:0] unit_op2;
  logic [63:0] unit_result;

  modport master (
    output unit_start, unit_abort, unit_inst, unit_op1, unit_op2,
    input  unit_result
  );

  modport slave (
    input  unit_start, unit_abort, unit_inst, unit_op1, unit_op2,
    output unit_result
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO: launches the
// multi-cycle unit, stalls EX while it runs and owns the HI/LO register.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 36
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 ex_valid,
  input  logic                 ex_hold,
  input  logic [7:0]           inst,
  input  logic [31:0]          op1,
  input  logic [31:0]          op2,
  muldiv_ctrl_if.master        unit,
  output logic                 stall_req,
  output logic                 busy,
  output logic [63:0]          hilo_o
);

  localparam logic [7:0] INST_MFHI  = 8'h10;
  localparam logic [7:0] INST_MTHI  = 8'h11;
  localparam logic [7:0] INST_MFLO  = 8'h12;
  localparam logic [7:0] INST_MTLO  = 8'h13;
  localparam logic [7:0] INST_MULT  = 8'h18;
  localparam logic [7:0] INST_MULTU = 8'h19;
  localparam logic [7:0] INST_DIV   = 8'h1A;
  localparam logic [7:0] INST_DIVU  = 8'h1B;

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   hilo;

  logic is_mul;
  logic is_div;
  logic is_muldiv;

  always_comb begin
    is_mul    = (inst == INST_MULT) || (inst == INST_MULTU);
    is_div    = (inst == INST_DIV)  || (inst == INST_DIVU);
    is_muldiv = ex_valid && (is_mul || is_div);
  end

  // The IDLE stall must appear in the detection cycle itself, so it is
  // decoded combinationally; flush and reset always win over it.
  assign stall_req = rst_n && !flush &&
                     (((state == IDLE) && is_muldiv) || (state == BUSY));
  assign busy      = (state != IDLE);
  assign hilo_o    = hilo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      hilo            <= '0;
      unit.unit_start <= 1'b0;
      unit.unit_abort <= 1'b0;
      unit.unit_inst  <= '0;
      unit.unit_op1   <= '0;
      unit.unit_op2   <= '0;
    end else begin
      unit.unit_start <= 1'b0;
      unit.unit_abort <= 1'b0;
      if (flush) begin
        state           <= IDLE;
        cnt             <= '0;
        unit.unit_abort <= (state == BUSY);
      end else begin
        case (state)
          IDLE: begin
            if (is_muldiv) begin
              unit.unit_inst <= inst;
              unit.unit_op1  <= op1;
              unit.unit_op2  <= op2;
              // Divide by zero never reaches the unit and leaves HI/LO alone.
              if (is_div && (op2 == '0)) begin
                state <= DONE;
              end else begin
                unit.unit_start <= 1'b1;
                state           <= BUSY;
                cnt             <= is_div ? DIV_LOAD : MUL_LOAD;
              end
            end else if (ex_valid && !ex_hold) begin
              if (inst == INST_MTHI) begin
                hilo[63:32] <= op1;
              end else if (inst == INST_MTLO) begin
                hilo[31:0] <= op1;
              end
            end
          end
          BUSY: begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              hilo  <= unit.unit_result;
              state <= DONE;
            end
          end
          DONE: begin
            // The finished instruction is still on inst; leave only once EX advances.
            if (!ex_hold) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with a behavioural
// multiply/divide unit and a queue of expected HI/LO values.
module tb_muldiv_ctrl;

  localparam int MUL_N = 3;
  localparam int DIV_N = 36;

  localparam logic [7:0] INST_MFHI  = 8'h10;
  localparam logic [7:0] INST_MTHI  = 8'h11;
  localparam logic [7:0] INST_MTLO  = 8'h13;
  localparam logic [7:0] INST_MULT  = 8'h18;
  localparam logic [7:0] INST_MULTU = 8'h19;
  localparam logic [7:0] INST_DIV   = 8'h1A;
  localparam logic [7:0] INST_DIVU  = 8'h1B;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        ex_valid;
  logic        ex_hold;
  logic [7:0]  inst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        stall_req;
  logic        busy;
  logic [63:0] hilo_o;

  int n_checks = 0;
  int n_fail   = 0;
  int start_count = 0;
  int abort_count = 0;

  logic [63:0] exp_q[$];

  muldiv_ctrl_if unit_bus ();

  muldiv_ctrl #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .ex_valid (ex_valid),
    .ex_hold  (ex_hold),
    .inst     (inst),
    .op1      (op1),
    .op2      (op2),
    .unit     (unit_bus),
    .stall_req(stall_req),
    .busy     (busy),
    .hilo_o   (hilo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unit: result is a pure function of the latched operands.
  function automatic logic [63:0] unit_model(input logic [7:0] code,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (code)
      INST_MULT:  return sa * sb;
      INST_MULTU: return {32'b0, a} * {32'b0, b};
      INST_DIV: begin
        if (b == 32'd0) return 64'd0;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      INST_DIVU: begin
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  always_comb unit_bus.unit_result = unit_model(unit_bus.unit_inst, unit_bus.unit_op1, unit_bus.unit_op2);

  always @(posedge clk) begin
    if (unit_bus.unit_start) start_count <= start_count + 1;
    if (unit_bus.unit_abort) abort_count <= abort_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_hilo(input string tag);
    logic [63:0] expected;
    if (exp_q.size() == 0) expected = 'x;
    else expected = exp_q.pop_front();
    check(tag, hilo_o, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic h, input logic f,
                                input logic [7:0] code, input logic [31:0] a,
                                input logic [31:0] b);
    ex_valid = v;
    ex_hold  = h;
    flush    = f;
    inst     = code;
    op1      = a;
    op2      = b;
  endtask

  // Full launch-to-retire sequence; hold_cycles extra DONE cycles with ex_hold=1.
  task automatic run_op(input logic [7:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [63:0] exp_hilo, input int hold_cycles,
                        input string tag);
    int stalls;
    int starts0;
    stalls  = 0;
    starts0 = start_count;
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, code, a, b);
    exp_q.push_back(exp_hilo);
    @(negedge clk);
    if (stall_req) stalls++;
    check({tag, "_c0_busy"}, 64'(busy), 64'd0);
    for (int c = 1; c <= n; c++) begin
      tick();
      @(negedge clk);
      if (stall_req) stalls++;
      if (c == 1) begin
        check({tag, "_start"}, 64'(unit_bus.unit_start), 64'd1);
        check({tag, "_op"}, {unit_bus.unit_op1, unit_bus.unit_op2}, {a, b});
        check({tag, "_inst"}, 64'(unit_bus.unit_inst), 64'(code));
      end
    end
    tick();
    ex_hold = (hold_cycles > 0);
    @(negedge clk);
    check({tag, "_done_stall"}, 64'(stall_req), 64'd0);
    check({tag, "_done_busy"}, 64'(busy), 64'd1);
    check_hilo({tag, "_hilo"});
    for (int h = 1; h <= hold_cycles; h++) begin
      tick();
      ex_hold = (h < hold_cycles);
      @(negedge clk);
      check({tag, "_hold_busy"}, {63'd0, busy}, 64'd1);
      check({tag, "_hold_stall"}, {63'd0, stall_req}, 64'd0);
    end
    check({tag, "_op_held"}, {unit_bus.unit_op1, unit_bus.unit_op2}, {a, b});
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(n + 1));
    check({tag, "_one_start"}, 64'(start_count - starts0), 64'd1);
  endtask

  task automatic mt_write(input logic [7:0] code, input logic [31:0] value);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, code, value, 32'd0);
    @(negedge clk);
    check("mt_stall", 64'(stall_req), 64'd0);
  endtask

  initial begin
    int starts0;
    rst_n = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, INST_MULT, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", hilo_o, 64'd0);
    check("rst_pulses", {62'd0, unit_bus.unit_start, unit_bus.unit_abort}, 64'd0);
    check("rst_latch", {unit_bus.unit_op1, unit_bus.unit_op2}, 64'd0);
    check("rst_inst", 64'(unit_bus.unit_inst), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 32'd0);

    $display("[TB] MULT / DIVU / MULTU with DONE hold");
    run_op(INST_MULT, 32'hFFFF_FFFE, 32'd3, MUL_N, 64'hFFFF_FFFF_FFFF_FFFA, 0, "mult");
    run_op(INST_DIVU, 32'd100, 32'd7, DIV_N, 64'h0000_0002_0000_000E, 0, "divu");
    run_op(INST_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_N, 64'h0000_0001_FFFF_FFFE, 3, "hold");

    $display("[TB] MTHI/MTLO then MFHI");
    mt_write(INST_MTHI, 32'hDEAD_BEEF);
    mt_write(INST_MTLO, 32'h1234_5678);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, INST_MFHI, 32'd0, 32'd0);
    exp_q.push_back(64'hDEAD_BEEF_1234_5678);
    @(negedge clk);
    check_hilo("mfhi_hilo");
    check("mfhi_stall", 64'(stall_req), 64'd0);

    tick();
    apply_stimulus(1'b1, 1'b1, 1'b0, INST_MTHI, 32'hCAFE_F00D, 32'd0);
    tick();
    @(negedge clk);
    check("mthi_held", hilo_o, 64'hDEAD_BEEF_1234_5678);
    tick();
    ex_hold = 1'b0;
    @(negedge clk);
    check("mthi_pre_write", hilo_o, 64'hDEAD_BEEF_1234_5678);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_after_hold", hilo_o, 64'hCAFE_F00D_1234_5678);

    $display("[TB] divide by zero");
    mt_write(INST_MTHI, 32'h1111_1111);
    mt_write(INST_MTLO, 32'h2222_2222);
    starts0 = start_count;
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, INST_DIV, 32'd5, 32'd0);
    exp_q.push_back(64'h1111_1111_2222_2222);
    @(negedge clk);
    check("div0_stall", 64'(stall_req), 64'd1);
    tick();
    @(negedge clk);
    check("div0_done", {62'd0, busy, stall_req}, 64'd2);
    check("div0_nostart", 64'(unit_bus.unit_start), 64'd0);
    check_hilo("div0_hilo");
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 32'd0);
    @(negedge clk);
    check("div0_idle", 64'(busy), 64'd0);
    check("div0_starts", 64'(start_count - starts0), 64'd0);

    $display("[TB] flush on last DIV cycle");
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, INST_DIV, 32'hFFFF_FF9C, 32'd7);
    for (int c = 1; c < DIV_N; c++) tick();
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(stall_req), 64'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 32'd0);
    exp_q.push_back(64'h1111_1111_2222_2222);
    @(negedge clk);
    check("flush_abort", 64'(unit_bus.unit_abort), 64'd1);
    check("flush_idle", 64'(busy), 64'd0);
    check_hilo("flush_hilo");
    tick();
    @(negedge clk);
    check("abort_one_pulse", {63'd0, unit_bus.unit_abort}, 64'd0);
    check("abort_count", 64'(abort_count), 64'd1);

    $display("[TB] flush in detection cycle");
    starts0 = start_count;
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b1, INST_MULT, 32'd7, 32'd6);
    @(negedge clk);
    check("flushdet_stall", 64'(stall_req), 64'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 32'd0);
    @(negedge clk);
    check("flushdet_idle", {62'd0, busy, unit_bus.unit_start}, 64'd0);
    tick();
    @(negedge clk);
    check("flushdet_starts", 64'(start_count - starts0), 64'd0);

    $display("[TB] async reset mid-operation");
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, INST_MULT, 32'd7, 32'd6);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_state", {62'd0, busy, stall_req}, 64'd0);
    check("arst_hilo", hilo_o, 64'd0);
    tick();
    @(negedge clk);
    check("arst_noabort", {63'd0, unit_bus.unit_abort}, 64'd0);
    check("arst_abort_count", 64'(abort_count), 64'd1);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 32'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
